// File: rtl/instr_compressor.sv
// Pair-based instruction compressor: holds one instruction and replaces a
// (held, incoming) pair found in the token table with a single token word.
module instr_compressor #(
  parameter int                      WIDTH        = 32,
  parameter int                      encodeLength = 4,
  parameter logic [encodeLength-1:0] OPcode       = 4'b1111,
  parameter int                      NPAIRS       = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  input  logic                           in_flush,
  input  logic                           wme,
  input  logic [$clog2(NPAIRS):0]        waddr,
  input  logic [WIDTH-1:0]               wdata,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic                           out_is_token,
  output logic [15:0]                    tok_count,
  output logic                           err_opcode
);

  localparam int AW = $clog2(NPAIRS);
  localparam int LW = WIDTH - encodeLength;

  // Handshake: a word moves on either port only in a cycle where valid and
  // ready are both high at the rising edge; out_data/out_is_token are held
  // stable while out_valid is high and out_ready is low.

  typedef enum logic {HOLD_EMPTY, HOLD_FULL} hold_state_t;

  hold_state_t             state, state_n;
  logic [WIDTH-1:0]        hold_data;
  logic [WIDTH-1:0]        first  [NPAIRS];
  logic [WIDTH-1:0]        second [NPAIRS];
  logic [NPAIRS-1:0]       valid;
  logic [AW-1:0]           widx;
  logic                    load_ok;
  logic                    accept;
  logic                    match;
  logic [AW-1:0]           match_idx;
  logic [LW-1:0]           tok_low;
  logic                    hold_load;
  logic                    out_load;
  logic [WIDTH-1:0]        out_load_data;
  logic                    out_load_tok;

  assign widx     = waddr[AW:1];
  assign load_ok  = !out_valid || out_ready;
  assign in_ready = reset && !in_flush && (state == HOLD_EMPTY || load_ok);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid <= '0;
    end else if (wme) begin
      if (waddr[0]) begin
        second[widx] <= wdata;
        valid[widx]  <= 1'b1;
      end else begin
        first[widx]  <= wdata;
        valid[widx]  <= 1'b0;
      end
    end
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int k = NPAIRS - 1; k >= 0; k--) begin
      if (valid[k] && first[k] == hold_data && second[k] == in_data) begin
        match     = 1'b1;
        match_idx = AW'(k);
      end
    end
    if (hold_data[WIDTH-1 -: encodeLength] == OPcode ||
        in_data[WIDTH-1 -: encodeLength] == OPcode) begin
      match = 1'b0;
    end
  end

  assign tok_low = LW'(match_idx) << 3;

  always_comb begin
    state_n       = state;
    hold_load     = 1'b0;
    out_load      = 1'b0;
    out_load_data = hold_data;
    out_load_tok  = 1'b0;
    case (state)
      HOLD_EMPTY: begin
        if (accept) begin
          hold_load = 1'b1;
          state_n   = HOLD_FULL;
        end
      end
      HOLD_FULL: begin
        if (accept) begin
          out_load = 1'b1;
          if (match) begin
            out_load_data = {OPcode, tok_low};
            out_load_tok  = 1'b1;
            state_n       = HOLD_EMPTY;
          end else begin
            hold_load = 1'b1;
          end
        end else if (in_flush && load_ok) begin
          out_load = 1'b1;
          state_n  = HOLD_EMPTY;
        end
      end
      default: state_n = HOLD_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= HOLD_EMPTY;
      hold_data    <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_is_token <= 1'b0;
      tok_count    <= '0;
      err_opcode   <= 1'b0;
    end else begin
      state <= state_n;
      if (hold_load) hold_data <= in_data;
      if (out_load) begin
        out_valid    <= 1'b1;
        out_data     <= out_load_data;
        out_is_token <= out_load_tok;
        if (out_load_tok && tok_count != 16'hFFFF) tok_count <= tok_count + 16'd1;
        if (!out_load_tok && out_load_data[WIDTH-1 -: encodeLength] == OPcode) begin
          err_opcode <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_compressor.sv
// Directed bench for instr_compressor: token matching, raw pass-through,
// back-pressure, opcode collisions, table rewrite and mid-stream reset.
module tb_instr_compressor;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_flush;
  logic        wme;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_is_token;
  logic [15:0] tok_count;
  logic        err_opcode;

  int tests;
  int fails;

  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];

  instr_compressor dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_flush     (in_flush),
    .wme          (wme),
    .waddr        (waddr),
    .wdata        (wdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_is_token (out_is_token),
    .tok_count    (tok_count),
    .err_opcode   (err_opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every word the consumer takes, as {is_token, data}.
  always @(posedge clk) begin
    if (reset && out_valid && out_ready) got_q.push_back({out_is_token, out_data});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wme = 1'b1;
    waddr = a;
    wdata = d;
    tick();
    wme = 1'b0;
  endtask

  task automatic send(input logic [31:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    #1;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("send ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic flush();
    in_flush = 1'b1;
    tick();
    in_flush = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic tok, input logic [31:0] d);
    int n;
    logic [32:0] g;
    logic [32:0] e;
    n = 0;
    exp_q.push_back({tok, d});
    while (got_q.size() == 0 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " present"}, 32'(got_q.size() != 0), 32'd1);
    e = exp_q.pop_front();
    if (got_q.size() != 0) begin
      g = got_q.pop_front();
      chk({tag, " data"}, g[31:0], e[31:0]);
      chk({tag, " tok"}, 32'(g[32]), 32'(e[32]));
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_flush = 1'b0;
    wme = 1'b0;
    waddr = '0;
    wdata = '0;
    out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_data", out_data, 32'h0);
    chk("rst out_is_token", 32'(out_is_token), 32'd0);
    chk("rst tok_count", 32'(tok_count), 32'd0);
    chk("rst err_opcode", 32'(err_opcode), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    tick();

    // Entry 2 pair compresses to token 0xF0000010
    wr(5'd4, 32'h00A00093);
    wr(5'd5, 32'h00100113);
    send(32'h00A00093);
    send(32'h00100113);
    chk("tok1 out_valid", 32'(out_valid), 32'd1);
    chk("tok1 out_data", out_data, 32'hF0000010);
    chk("tok1 out_is_token", 32'(out_is_token), 32'd1);
    chk("tok1 tok_count", 32'(tok_count), 32'd1);
    expect_out("tok1", 1'b1, 32'hF0000010);

    // Unmatched words pass through raw, in order
    send(32'h11111111);
    send(32'h22222222);
    send(32'h33333333);
    flush();
    chk("raw3 last", out_data, 32'h33333333);
    expect_out("raw1", 1'b0, 32'h11111111);
    expect_out("raw2", 1'b0, 32'h22222222);
    expect_out("raw3", 1'b0, 32'h33333333);

    // Duplicate pair in entries 3 and 5: lowest index wins
    wr(5'd10, 32'h12345678);
    wr(5'd11, 32'h0BADF00D);
    wr(5'd6, 32'h12345678);
    wr(5'd7, 32'h0BADF00D);
    send(32'h12345678);
    send(32'h0BADF00D);
    chk("dup out_data", out_data, 32'hF0000018);
    chk("dup tok_count", 32'(tok_count), 32'd2);
    expect_out("dup", 1'b1, 32'hF0000018);

    // Back-pressure with hold and output both full
    out_ready = 1'b0;
    send(32'h01010101);
    send(32'h02020202);
    in_valid = 1'b1;
    in_data = 32'h03030303;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall in_ready", 32'(in_ready), 32'd0);
      chk("stall out_valid", 32'(out_valid), 32'd1);
      chk("stall out_data", out_data, 32'h01010101);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    chk("release in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush();
    expect_out("bp1", 1'b0, 32'h01010101);
    expect_out("bp2", 1'b0, 32'h02020202);
    expect_out("bp3", 1'b0, 32'h03030303);

    // Raw word carrying the marker sets the sticky error
    send(32'hF0000004);
    flush();
    chk("opc out_data", out_data, 32'hF0000004);
    chk("opc out_is_token", 32'(out_is_token), 32'd0);
    chk("opc err_opcode", 32'(err_opcode), 32'd1);
    expect_out("opc", 1'b0, 32'hF0000004);

    // A table pair containing the marker never matches
    wr(5'd2, 32'hF0000004);
    wr(5'd3, 32'h00000001);
    send(32'hF0000004);
    send(32'h00000001);
    chk("opcpair out_is_token", 32'(out_is_token), 32'd0);
    chk("opcpair out_data", out_data, 32'hF0000004);
    flush();
    expect_out("opcpair1", 1'b0, 32'hF0000004);
    expect_out("opcpair2", 1'b0, 32'h00000001);
    chk("opc sticky", 32'(err_opcode), 32'd1);
    chk("opc tok_count", 32'(tok_count), 32'd2);

    // Rewriting the first word invalidates entry 2
    wr(5'd4, 32'h00A00097);
    send(32'h00A00093);
    out_ready = 1'b0;
    send(32'h00100113);
    chk("rewr out_valid", 32'(out_valid), 32'd1);
    chk("rewr out_data", out_data, 32'h00A00093);
    chk("rewr out_is_token", 32'(out_is_token), 32'd0);

    // Reset mid-stream with a table write in the same cycle
    reset = 1'b0;
    wme = 1'b1;
    waddr = 5'd5;
    wdata = 32'h00100113;
    tick();
    wme = 1'b0;
    chk("mid out_valid", 32'(out_valid), 32'd0);
    chk("mid out_data", out_data, 32'h0);
    chk("mid out_is_token", 32'(out_is_token), 32'd0);
    chk("mid tok_count", 32'(tok_count), 32'd0);
    chk("mid err_opcode", 32'(err_opcode), 32'd0);
    chk("mid in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("mid discarded", 32'(got_q.size()), 32'd0);
    chk("mid idle", 32'(out_valid), 32'd0);
    send(32'h00A00097);
    send(32'h00100113);
    flush();
    expect_out("post1", 1'b0, 32'h00A00097);
    expect_out("post2", 1'b0, 32'h00100113);
    chk("post tok_count", 32'(tok_count), 32'd0);
    chk("post leftover", 32'(got_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_compressor.md
INSTR_COMPRESSOR -- requirements
Module: instr_compressor

Interface
REQ-001 Parameter WIDTH, default 32: instruction and token word width.
REQ-002 Parameter OPcode, default 4'b1111: token marker placed in the top encodeLength bits.
REQ-003 Parameter encodeLength, default 4: width of the token marker field.
REQ-004 Parameter NPAIRS, default 16 (power of 2): number of pair entries in the token table.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 in_valid  in  1  in_data holds an uncompressed instruction.
REQ-008 in_ready  out  1  input accepted this cycle when in_valid && in_ready.
REQ-009 in_data  in  WIDTH  uncompressed instruction.
REQ-010 in_flush  in  1  level request to emit any held instruction (stream boundary or branch target).
REQ-011 wme  in  1  table write enable.
REQ-012 waddr  in  log2(NPAIRS)+1  {entry index, word select}; bit 0 = 0 selects first word, 1 selects second word.
REQ-013 wdata  in  WIDTH  table write data.
REQ-014 out_valid  out  1  out_data valid.
REQ-015 out_ready  in  1  consumer takes out_data when out_valid && out_ready.
REQ-016 out_data  out  WIDTH  raw instruction or token.
REQ-017 out_is_token  out  1  out_data is a token.
REQ-018 tok_count  out  16  count of tokens emitted, saturating.
REQ-019 err_opcode  out  1  sticky: a raw instruction whose top encodeLength bits equal OPcode was emitted.

Function
REQ-020 Table entry k holds first[k], second[k] and valid[k]; a write with waddr[0]=0 loads first[k] and clears valid[k]; a write with waddr[0]=1 loads second[k] and sets valid[k].
REQ-021 Table writes take effect at the next edge; a match evaluated in the same cycle uses the pre-write contents.
REQ-022 Token for entry k = {OPcode, (k<<3) zero-extended to WIDTH-encodeLength bits}, so the pair sits at table byte addresses 8k and 8k+4 for the decompressor.
REQ-023 State: hold register (hold_valid, hold_data) plus a single output register; state HOLD_EMPTY or HOLD_FULL, with the output register either FULL or EMPTY.
REQ-024 load_ok = !out_valid || out_ready.
REQ-025 in_ready = !in_flush && (!hold_valid || load_ok).
REQ-026 Accept while HOLD_EMPTY: hold_data <= in_data, go to HOLD_FULL; no output load.
REQ-027 Accept while HOLD_FULL: match = exists valid k with first[k]==hold_data && second[k]==in_data; lowest matching k wins.
REQ-028 On match: output <= token, out_is_token=1, hold empties, tok_count increments and saturates at 16'hFFFF.
REQ-029 On no match: output <= hold_data raw, out_is_token=0, hold_data <= in_data, stay in HOLD_FULL.
REQ-030 A pair where either word has top encodeLength bits == OPcode never matches.
REQ-031 Flush: if in_flush && hold_valid && load_ok, output <= hold_data raw and hold empties; with in_flush high and hold empty, the block idles.
REQ-032 Output register is cleared (out_valid=0) when consumed and not reloaded in the same cycle; out_data and out_is_token stay stable while out_valid && !out_ready.
REQ-033 err_opcode sets in any cycle a raw word with top bits == OPcode loads into the output register; it clears only on reset.
REQ-034 Latency: a token appears in out_data one cycle after the second word of the pair is accepted; a raw word appears one cycle after its successor is accepted or after flush is honoured.
REQ-035 Output order equals input order; no instruction is dropped or duplicated.

Reset
REQ-036 While reset=0 at an edge: hold_valid=0, out_valid=0, out_data=0, out_is_token=0, tok_count=0, err_opcode=0, all valid[k]=0; a table write in that cycle is ignored.
REQ-037 Reset mid-stream discards held and output contents without emitting them.
REQ-038 in_ready=0 during a reset cycle.

Verification
REQ-039 Load entry 2 = (0x00A00093, 0x00100113); send both words, out_ready=1 -> one output 0xF0000010, out_is_token=1, tok_count=1.
REQ-040 Send 0x11111111, 0x22222222, 0x33333333, then flush, with no table match -> three raw outputs in order, out_is_token=0.
REQ-041 Entries 3 and 5 both hold the same pair -> token 0xF0000018 (lowest index wins).
REQ-042 out_ready=0 for 5 cycles with hold and output full -> in_ready=0, out_data stable; release -> stream resumes with no loss.
REQ-043 Send raw 0xF0000004 then flush -> emitted raw, err_opcode=1 and stays 1 until reset.
REQ-044 Rewrite entry 2's first word, then send the old pair -> no match, two raw outputs; drive reset=0 mid-stream -> all outputs return to 0 next edge.
